// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encodings and the 4x4 key map for the keypad entry controller.
package keypad_pkg;

    typedef enum logic [3:0] {
        KEY_D0   = 4'd0,
        KEY_D1   = 4'd1,
        KEY_D2   = 4'd2,
        KEY_D3   = 4'd3,
        KEY_D4   = 4'd4,
        KEY_D5   = 4'd5,
        KEY_D6   = 4'd6,
        KEY_D7   = 4'd7,
        KEY_D8   = 4'd8,
        KEY_D9   = 4'd9,
        KEY_CLR  = 4'd10,
        KEY_ENT  = 4'd11,
        KEY_BS   = 4'd12,
        KEY_NEG  = 4'd13,
        KEY_NONE = 4'd15
    } key_code_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REL = 3'd1,
        ST_ARMED    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Indexed by {row, col}; row 0 / col 0 correspond to nibble bit 3 pulled low.
    localparam key_code_e KEY_MAP [16] = '{
        KEY_D1,  KEY_D2, KEY_D3,  KEY_BS,
        KEY_D4,  KEY_D5, KEY_D6,  KEY_NEG,
        KEY_D7,  KEY_D8, KEY_D9,  KEY_NONE,
        KEY_CLR, KEY_D0, KEY_ENT, KEY_NONE
    };

    // Returns {exactly_one_low, index}; index 0 is bit 3.
    function automatic logic [2:0] onehot_low_idx(input logic [3:0] nib);
        logic [2:0] res;
        case (nib)
            4'b0111: res = 3'b100;
            4'b1011: res = 3'b101;
            4'b1101: res = 3'b110;
            4'b1110: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_coord_decoder.sv
// Combinational decode of the scanner's {row,col} active-low coordinate into a key code.
module keypad_coord_decoder
    import keypad_pkg::*;
(
    input  logic [7:0] i_coord,
    output logic       o_valid,
    output key_code_e  o_code
);

    logic [2:0] w_row;
    logic [2:0] w_col;

    // Reject anything that is not exactly one low line per nibble.
    always_comb begin
        w_row   = onehot_low_idx(i_coord[7:4]);
        w_col   = onehot_low_idx(i_coord[3:0]);
        o_valid = w_row[2] & w_col[2];
        if (o_valid) begin
            o_code = KEY_MAP[{w_row[1:0], w_col[1:0]}];
        end else begin
            o_code = KEY_NONE;
        end
    end

endmodule

// File: rtl/keypad_entry_controller.sv
// Keypad number-entry sequencer: press/release tracking, key application and CPU handoff.
module keypad_entry_controller
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2_500_000,
    parameter int RELEASE_CYCLES = 1_000_000,
    parameter int MAX_DIGITS     = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    input  logic [7:0]  key_coord,
    input  logic        enable,
    input  logic        data_ack,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic [31:0] cur_value,
    output logic [3:0]  digit_cnt,
    output logic        busy
);

    localparam int SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);
    localparam logic [3:0]    MAX_DIG  = 4'(MAX_DIGITS);

    state_e        r_state;
    logic [SW-1:0] r_set_cnt;
    logic [RW-1:0] r_rel_cnt;
    logic [31:0]   r_accum;
    logic          r_neg;
    logic [3:0]    r_digit_cnt;
    logic          r_data_valid;
    logic [31:0]   r_data_out;

    logic          w_key_valid;
    key_code_e     w_key_code;
    logic          w_row_idle;
    logic [31:0]   w_cur_value;
    logic [31:0]   w_accum_push;

    keypad_coord_decoder u_dec (
        .i_coord (key_coord),
        .o_valid (w_key_valid),
        .o_code  (w_key_code)
    );

    assign w_row_idle  = (row_in == 4'hf);
    assign w_cur_value = r_neg ? (32'd0 - r_accum) : r_accum;
    // Low 32 bits of accum*10+d are identical whether computed at 32 or 36 bits.
    assign w_accum_push = (r_accum * 32'd10) + {28'd0, w_key_code};

    assign data_valid = r_data_valid;
    assign data_out   = r_data_out;
    assign cur_value  = w_cur_value;
    assign digit_cnt  = r_digit_cnt;
    assign busy       = (r_state != ST_IDLE);

    // Entry FSM with accumulator; enable low overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_set_cnt    <= '0;
            r_rel_cnt    <= '0;
            r_accum      <= 32'd0;
            r_neg        <= 1'b0;
            r_digit_cnt  <= 4'd0;
            r_data_valid <= 1'b0;
            r_data_out   <= 32'd0;
        end else if (!enable) begin
            r_state      <= ST_IDLE;
            r_set_cnt    <= '0;
            r_rel_cnt    <= '0;
            r_accum      <= 32'd0;
            r_neg        <= 1'b0;
            r_digit_cnt  <= 4'd0;
            r_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_WAIT_REL;
                    r_rel_cnt <= '0;
                end
                ST_WAIT_REL: begin
                    if (!w_row_idle) begin
                        r_rel_cnt <= '0;
                    end else if (r_rel_cnt == REL_LAST) begin
                        r_state <= ST_ARMED;
                    end else begin
                        r_rel_cnt <= r_rel_cnt + RW'(1);
                    end
                end
                ST_ARMED: begin
                    if (!w_row_idle) begin
                        r_state   <= ST_SETTLE;
                        r_set_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_row_idle) begin
                        r_state <= ST_ARMED;
                    end else if (r_set_cnt != SET_LAST) begin
                        r_set_cnt <= r_set_cnt + SW'(1);
                    end else begin
                        r_state   <= ST_WAIT_REL;
                        r_rel_cnt <= '0;
                        if (w_key_valid) begin
                            case (w_key_code)
                                KEY_ENT: begin
                                    r_data_out   <= w_cur_value;
                                    r_data_valid <= 1'b1;
                                    r_state      <= ST_DONE;
                                end
                                KEY_CLR: begin
                                    r_accum     <= 32'd0;
                                    r_neg       <= 1'b0;
                                    r_digit_cnt <= 4'd0;
                                end
                                KEY_BS: begin
                                    if (r_digit_cnt != 4'd0) begin
                                        r_accum     <= r_accum / 32'd10;
                                        r_digit_cnt <= r_digit_cnt - 4'd1;
                                    end
                                end
                                KEY_NEG:  r_neg <= ~r_neg;
                                KEY_NONE: r_neg <= r_neg;
                                default: begin
                                    if (r_digit_cnt < MAX_DIG) begin
                                        r_accum     <= w_accum_push;
                                        r_digit_cnt <= r_digit_cnt + 4'd1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    if (data_ack) begin
                        r_data_valid <= 1'b0;
                        r_accum      <= 32'd0;
                        r_neg        <= 1'b0;
                        r_digit_cnt  <= 4'd0;
                        r_state      <= ST_WAIT_REL;
                        r_rel_cnt    <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Randomized scoreboard bench for keypad_entry_controller against a digit-list reference model.
module tb_keypad_entry_controller;

    localparam int S = 8;
    localparam int R = 4;
    localparam int M = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in = 4'hf;
    logic [7:0]  key_coord = 8'hff;
    logic        enable = 1'b0;
    logic        data_ack = 1'b0;
    logic        data_valid;
    logic [31:0] data_out;
    logic [31:0] cur_value;
    logic [3:0]  digit_cnt;
    logic        busy;

    keypad_entry_controller #(
        .SETTLE_CYCLES  (S),
        .RELEASE_CYCLES (R),
        .MAX_DIGITS     (M)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .key_coord  (key_coord),
        .enable     (enable),
        .data_ack   (data_ack),
        .data_valid (data_valid),
        .data_out   (data_out),
        .cur_value  (cur_value),
        .digit_cnt  (digit_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] val;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    // Reference model: the typed digits as a list plus a sign flag.
    int    dq[$];
    bit    mneg = 1'b0;
    string KM = "123A456B789C*0#D";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mval();
        int v = 0;
        foreach (dq[i]) v = v * 10 + dq[i];
        return mneg ? -v : v;
    endfunction

    function automatic int code_of(input int p);
        byte ch = KM[p];
        if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
        case (ch)
            "*":     return 10;
            "#":     return 11;
            "A":     return 12;
            "B":     return 13;
            default: return 15;
        endcase
    endfunction

    function automatic int pos_of(input byte ch);
        for (int p = 0; p < 16; p++) if (KM[p] == ch) return p;
        return 15;
    endfunction

    task automatic model_clear();
        dq.delete();
        mneg = 1'b0;
    endtask

    task automatic model_apply(input int code);
        if (code <= 9) begin
            if (dq.size() < M) dq.push_back(code);
        end else if (code == 10) begin
            model_clear();
        end else if (code == 12) begin
            if (dq.size() > 0) void'(dq.pop_back());
        end else if (code == 13) begin
            mneg = ~mneg;
        end
    endtask

    // Monitor: every rising data_valid consumes one scoreboard entry.
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (data_valid && !prev_dv) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("data_out", data_out, e.val);
                chk("digit_cnt_done", {28'd0, digit_cnt}, e.cnt);
            end
        end
        prev_dv = data_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] coord_of(input int p);
        logic [3:0] rn;
        logic [3:0] cn;
        rn = ~(4'b1000 >> (p / 4));
        cn = ~(4'b1000 >> (p % 4));
        return {rn, cn};
    endfunction

    task automatic press_raw(input logic [7:0] coord, input logic [3:0] rows, input int hold);
        key_coord = coord;
        row_in    = rows;
        cyc(hold);
        row_in    = 4'hf;
    endtask

    task automatic check_live(input string tag);
        chk({tag, "_cur"}, cur_value, 32'(mval()));
        chk({tag, "_cnt"}, {28'd0, digit_cnt}, 32'(dq.size()));
    endtask

    task automatic press_key(input int p);
        int   code;
        int   t;
        exp_t e;
        logic [7:0] c;
        code = code_of(p);
        c    = coord_of(p);
        if (code == 11) begin
            e.val = 32'(mval());
            e.cnt = 32'(dq.size());
            sb.push_back(e);
        end
        press_raw(c, c[7:4], S + 3);
        if (code == 11) begin
            t = 0;
            while (!data_valid && t < 50) begin
                cyc(1);
                t++;
            end
            chk("valid_seen", {31'd0, data_valid}, 32'd1);
            data_ack = 1'b1;
            cyc(1);
            data_ack = 1'b0;
            model_clear();
            chk("valid_after_ack", {31'd0, data_valid}, 32'd0);
            check_live("after_ack");
            cyc(R + 3);
        end else begin
            model_apply(code);
            cyc(R + 3);
            check_live("key");
        end
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) press_key(pos_of(s[i]));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_cur", cur_value, 32'd0);
        chk("rst_cnt", {28'd0, digit_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc(R + 3);
        chk("busy_enabled", {31'd0, busy}, 32'd1);

        type_str("123#");
        type_str("4567#");
        type_str("9A8B#");
        type_str("5*2#");

        // Short glitch must not apply a key.
        press_raw(coord_of(0), 4'b0111, 3);
        cyc(R + 3);
        check_live("glitch");

        // Key held while enable rises is ignored until released.
        enable = 1'b0;
        cyc(2);
        chk("busy_disabled", {31'd0, busy}, 32'd0);
        key_coord = coord_of(5);
        row_in    = 4'b1011;
        enable    = 1'b1;
        cyc(20);
        row_in = 4'hf;
        cyc(R + 3);
        check_live("held");
        type_str("#");

        type_str("33");
        press_raw(8'h37, 4'b0011, S + 3);
        cyc(R + 3);
        check_live("multikey");
        type_str("#");

        // Enable drop in the middle of SETTLE.
        type_str("4");
        press_raw(coord_of(8), 4'b1101, 3);
        enable = 1'b0;
        cyc(1);
        model_clear();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        check_live("abort");
        row_in = 4'hf;
        enable = 1'b1;
        cyc(R + 3);

        // Async reset while DONE.
        type_str("12");
        begin
            exp_t e;
            e.val = 32'(mval());
            e.cnt = 32'(dq.size());
            sb.push_back(e);
        end
        press_raw(coord_of(14), 4'b1110, S + 3);
        chk("done_valid", {31'd0, data_valid}, 32'd1);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        model_clear();
        chk("async_valid", {31'd0, data_valid}, 32'd0);
        chk("async_data", data_out, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        check_live("async");
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        data_ack = 1'b1;
        cyc(1);
        data_ack = 1'b0;
        cyc(1);
        chk("idle_ack_valid", {31'd0, data_valid}, 32'd0);
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);

        enable = 1'b1;
        cyc(R + 3);
        for (int e = 0; e < 30; e++) begin
            int nk;
            nk = int'($urandom_range(0, 6));
            for (int k = 0; k < nk; k++) begin
                int r;
                int p;
                r = int'($urandom_range(0, 9));
                p = int'($urandom_range(0, 15));
                if (r == 0) begin
                    press_raw(8'h3b, 4'b0011, S + 3);
                    cyc(R + 3);
                    check_live("rnd_invalid");
                end else if (r == 1) begin
                    press_raw(coord_of(p), coord_of(p) >> 4, int'($urandom_range(1, S - 2)));
                    cyc(2);
                    check_live("rnd_glitch");
                end else begin
                    if (code_of(p) == 11) p = 15;
                    press_key(p);
                end
            end
            press_key(pos_of("#"));
        end

        cyc(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
